// File: rtl/mult_bw_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter: slot state, id width
// derivation and the rotating-priority grant function.
package mult_bw_arb_pkg;

  localparam int unsigned MAX_REQ   = 32;
  localparam int unsigned MAX_IDX_W = 5;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_e;

  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot grant to the first asserted request scanning ptr, ptr+1, .. mod n.
  function automatic logic [MAX_REQ-1:0] rr_grant(input logic [MAX_REQ-1:0] req,
                                                  input int unsigned      ptr,
                                                  input int unsigned      n);
    logic [MAX_REQ-1:0] g;
    logic               found;
    int unsigned        idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < MAX_REQ; off++) begin
      if (off < n && !found) begin
        idx = ptr + off;
        if (idx >= n) idx = idx - n;
        if (req[idx[MAX_IDX_W-1:0]]) begin
          g[idx[MAX_IDX_W-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mult_bw_arb_if.sv
// Request/response bundle between the issuing units, the arbiter and the consumer.
interface mult_bw_arb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned A_DW = 8,
  parameter int unsigned B_DW = 8
);
  import mult_bw_arb_pkg::*;

  localparam int unsigned C_DW = A_DW + B_DW;
  localparam int unsigned ID_W = id_w(NREQ);

  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*A_DW-1:0] req_a_i;
  logic [NREQ*B_DW-1:0] req_b_i;
  logic                 resp_valid_o;
  logic                 resp_ready_i;
  logic [ID_W-1:0]      resp_id_o;
  logic [C_DW-1:0]      resp_c_o;

  modport master (
    output req_valid_i, req_a_i, req_b_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_id_o, resp_c_o
  );

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_id_o, resp_c_o
  );

endinterface

// File: rtl/mult_bw.sv
// Combinational signed multiplier: radix-4 Booth partial products reduced in
// carry-save form, one final carry-propagate add.
module mult_bw #(
  parameter int unsigned A_DW = 8,
  parameter int unsigned B_DW = 8
) (
  input  logic signed [A_DW-1:0]      a,
  input  logic signed [B_DW-1:0]      b,
  output logic signed [A_DW+B_DW-1:0] c
);

  localparam int unsigned C_DW = A_DW + B_DW;
  // One spare digit so the top Booth triplet always sees sign bits only.
  localparam int unsigned NPP  = B_DW / 2 + 1;
  localparam int unsigned BX_W = 2 * NPP + 1;

  logic [BX_W-1:0] bx;
  logic [C_DW-1:0] aext;
  logic [C_DW-1:0] pp;
  logic [C_DW-1:0] s;
  logic [C_DW-1:0] cy;
  logic [C_DW-1:0] ns;
  logic [2:0]      trip;

  assign bx   = {{(BX_W - 1 - B_DW){b[B_DW-1]}}, b, 1'b0};
  assign aext = {{B_DW{a[A_DW-1]}}, a};

  always_comb begin
    s    = '0;
    cy   = '0;
    pp   = '0;
    ns   = '0;
    trip = '0;
    for (int unsigned i = 0; i < NPP; i++) begin
      trip = bx[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = aext;
        3'b011:         pp = aext << 1;
        3'b100:         pp = -(aext << 1);
        3'b101, 3'b110: pp = -aext;
        default:        pp = '0;
      endcase
      pp = pp << (2 * i);
      ns = s ^ cy ^ pp;
      cy = ((s & cy) | (s & pp) | (cy & pp)) << 1;
      s  = ns;
    end
    c = s + cy;
  end

endmodule

// File: rtl/mult_bw_arb_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant plus its binary index.
module rr_arbiter
  import mult_bw_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            any
);

  always_comb begin
    grant     = NREQ'(rr_grant(MAX_REQ'(req), 32'(ptr), NREQ));
    grant_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant[k]) grant_idx = ID_W'(k);
    end
    any = |grant;
  end

endmodule

// File: rtl/mult_bw_arb.sv
// Round-robin sharing of one combinational multiplier among NREQ requesters,
// with a single registered, id-tagged response slot.
module mult_bw_arb
  import mult_bw_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned A_DW = 8,
  parameter int unsigned B_DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mult_bw_arb_if.slave  bus
);

  localparam int unsigned C_DW = A_DW + B_DW;
  localparam int unsigned ID_W = id_w(NREQ);

  slot_e                  state_q, state_d;
  logic                   load;
  logic [ID_W-1:0]        ptr_q;
  logic [ID_W-1:0]        gidx;
  logic [NREQ-1:0]        grant;
  logic                   any;
  logic                   can_accept;
  logic                   xfer;
  logic signed [A_DW-1:0] a_sel;
  logic signed [B_DW-1:0] b_sel;
  logic signed [C_DW-1:0] prod;
  logic [C_DW-1:0]        c_q;
  logic [ID_W-1:0]        id_q;

  assign can_accept = (state_q == S_EMPTY) || bus.resp_ready_i;
  assign xfer       = can_accept && any && !rst_i;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req       (bus.req_valid_i),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (gidx),
    .any       (any)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      a_sel |= bus.req_a_i[k*A_DW +: A_DW] & {A_DW{grant[k]}};
      b_sel |= bus.req_b_i[k*B_DW +: B_DW] & {B_DW{grant[k]}};
    end
  end

  mult_bw #(.A_DW(A_DW), .B_DW(B_DW)) u_mult (
    .a (a_sel),
    .b (b_sel),
    .c (prod)
  );

  // A full slot that drains and accepts in the same cycle stays full.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (xfer) begin
          state_d = S_FULL;
          load    = 1'b1;
        end
      end
      S_FULL: begin
        if (xfer) begin
          load = 1'b1;
        end else if (bus.resp_ready_i) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      ptr_q   <= '0;
      c_q     <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        c_q  <= prod;
        id_q <= gidx;
      end
      if (xfer) begin
        ptr_q <= (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + ID_W'(1);
      end
    end
  end

  assign bus.req_ready_o  = (can_accept && !rst_i) ? grant : '0;
  assign bus.resp_valid_o = (state_q == S_FULL);
  assign bus.resp_id_o    = id_q;
  assign bus.resp_c_o     = c_q;

endmodule
